hilo_acc_file: RTL
==================

// Module: hilo_acc_file
// PURPOSE
//  Parametrised HI/LO accumulator file: NACC independent HI:LO pairs of DW bits each.
//  Supports per-half direct writes (MTHI/MTLO/MULT-result) and signed/unsigned
//  accumulate add/sub of a 2*DW product (MADD/MSUB family).
//  Sits beside the EX-stage mult/div unit; read ports feed EX operand muxes.
//  Every op passes through one staging register, so commits stay in program order.
// PARAMETERS
//  DW    32  width of one half (HI or LO); accumulator is 2*DW
//  NACC  4   number of HI:LO pairs; IW = $clog2(NACC), min 1
// PORTS
//  clk       in   1      clock; all state updates on the FALLING edge of clk
//  rst       in   1      asynchronous, active-low reset (0 = reset)
//  op_valid  in   1      op request this cycle
//  op_ready  out  1      op accepted when op_valid & op_ready at the falling edge
//  op        in   2      hilo_pkg::op_e: OP_WR, OP_ADD, OP_SUB
//  op_signed in   1      signed overflow tracking for OP_ADD/OP_SUB
//  op_we     in   2      OP_WR only: [1]=write HI, [0]=write LO
//  op_idx    in   IW     target accumulator
//  op_hi     in   DW     OP_WR HI data
//  op_lo     in   DW     OP_WR LO data
//  op_prod   in   2*DW   OP_ADD/OP_SUB operand
//  stall     in   1      freezes the staging register, blocks commit
//  flush     in   1      discards the staged op and the incoming op
//  rd_idx    in   IW     read select (combinational)
//  rd_hi     out  DW     HI of rd_idx
//  rd_lo     out  DW     LO of rd_idx
//  rd_ovf    out  1      sticky signed-overflow flag of rd_idx
//  pend      out  1      staged op valid (uncommitted)
//  pend_idx  out  IW     staged op target, for hazard detection
// BEHAVIOUR
//  Reset (rst=0, async): all HI/LO = 0, all ovf = 0, staged valid = 0. Takes effect
//   immediately mid-op; the staged op is lost.
//  op_ready = ~stall.
//  Falling edge N accepts the op into the stage; falling edge N+1 commits it.
//   rd_* reflects the committed value after edge N+1.
//  Commit and accept happen on the same edge (1 op/cycle throughput).
//  Commit result is computed from the target's current register value:
//   OP_WR:  HI <- op_hi if we[1]; LO <- op_lo if we[0]; we=00 is a no-op commit.
//           we=11 also clears ovf[idx].
//   OP_ADD: {HI,LO} <- {HI,LO} + prod, mod 2^(2*DW).
//   OP_SUB: {HI,LO} <- {HI,LO} - prod, mod 2^(2*DW).
//   Signed ovf: operand signs agree (ADD) or differ (SUB) and the result sign
//    differs from the accumulator sign -> ovf[idx] <= 1 (sticky).
//    Unsigned ops never touch ovf.
//  Back-to-back ops to the same idx: the second sees the first's committed value.
//   The staging order guarantees this; no extra interlock is needed.
//  stall=1: stage holds, no commit, no accept. flush=1: staged valid <= 0 and the
//   incoming op is dropped. flush overrides stall. Nothing committed is undone.
//  pend = staged valid; pend_idx = staged idx (valid only while pend=1).
// CONFIGURATION
//  HILO_BYPASS_EN defined:
//   If pend & pend_idx==rd_idx & ~flush, rd_hi/rd_lo present the staged op's
//    would-be result (halves not written pass through) and rd_ovf its would-be flag.
//   Read-after-op then needs 0 stall cycles.
//  HILO_BYPASS_EN undefined:
//   rd_* shows committed state only.
//   The hazard unit stalls EX while pend & pend_idx==rd_idx.
// STRUCTURE
//  hilo_pkg: op_e enum (OP_WR=2'b00, OP_ADD=2'b01, OP_SUB=2'b10), staged-op struct
//   {valid,op,sgn,we,idx,hi,lo,prod}.
//  Sub-module hilo_acc_alu: combinational commit-result and ovf computation.
//   Shared by the commit path and the bypass path.
// TESTING
//  1 rst=0 mid-op: all rd_* = 0, pend = 0; release, then read idx 0..3 -> 0.
//  2 WR idx1 we=11 hi=0x1 lo=0x2; next cycle WR idx1 we=01 lo=0xFFFF_FFFF
//    -> rd idx1 = {0x1, 0xFFFF_FFFF}.
//  3 idx2 = 0, then ADD unsigned prod=0x1_0000_0001, then SUB prod=2, back-to-back
//    -> idx2 = 0xFFFF_FFFF after 2 commits.
//  4 idx0 = 0x7FFF_FFFF_FFFF_FFFF, ADD signed prod=1 -> 0x8000_..._0000,
//    rd_ovf=1; WR we=11 clears it.
//  5 accept ADD idx3, then flush with stall=1 -> idx3 unchanged, pend=0;
//    stall alone holds pend=1 for 3 cycles, then commits.
//  6 (BYPASS_EN) WR idx1 hi=0xA; rd_idx=1 in the cycle after accept
//    -> rd_hi=0xA before commit.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO accumulator file: op encoding and the staged-op control word.
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_e;

    // Control half of the staged op; the parameter-sized idx/hi/lo/prod fields sit beside it.
    typedef struct packed {
        logic       valid;
        op_e        op;
        logic       sgn;
        logic [1:0] we;
    } stage_ctrl_t;

endpackage

// File: rtl/hilo_acc_alu.sv
// Combinational commit-result and sticky-overflow computation for one HI:LO pair.
module hilo_acc_alu
    import hilo_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  op_e             op_i,
    input  logic            sgn_i,
    input  logic [1:0]      we_i,
    input  logic [DW-1:0]   acc_hi_i,
    input  logic [DW-1:0]   acc_lo_i,
    input  logic            acc_ovf_i,
    input  logic [DW-1:0]   wr_hi_i,
    input  logic [DW-1:0]   wr_lo_i,
    input  logic [2*DW-1:0] prod_i,
    output logic [DW-1:0]   res_hi_o,
    output logic [DW-1:0]   res_lo_o,
    output logic            res_ovf_o
);

    localparam int unsigned Msb = 2 * DW - 1;

    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] res;

    always_comb begin
        acc       = {acc_hi_i, acc_lo_i};
        res       = acc;
        res_hi_o  = acc_hi_i;
        res_lo_o  = acc_lo_i;
        res_ovf_o = acc_ovf_i;
        case (op_i)
            OP_WR: begin
                if (we_i[1]) res_hi_o = wr_hi_i;
                if (we_i[0]) res_lo_o = wr_lo_i;
                if (we_i == 2'b11) res_ovf_o = 1'b0;
            end
            OP_ADD: begin
                res = acc + prod_i;
                {res_hi_o, res_lo_o} = res;
                if (sgn_i && (acc[Msb] == prod_i[Msb]) && (res[Msb] != acc[Msb])) begin
                    res_ovf_o = 1'b1;
                end
            end
            OP_SUB: begin
                res = acc - prod_i;
                {res_hi_o, res_lo_o} = res;
                if (sgn_i && (acc[Msb] != prod_i[Msb]) && (res[Msb] != acc[Msb])) begin
                    res_ovf_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_acc_file.sv
// NACC-entry HI:LO accumulator file, falling-edge state, one staging register per op.
// Optional HILO_BYPASS_EN forwards the staged op's would-be result onto the read port.
module hilo_acc_file
    import hilo_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NACC = 4,
    localparam int unsigned IW  = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  op_e             op_i,
    input  logic            op_signed_i,
    input  logic [1:0]      op_we_i,
    input  logic [IW-1:0]   op_idx_i,
    input  logic [DW-1:0]   op_hi_i,
    input  logic [DW-1:0]   op_lo_i,
    input  logic [2*DW-1:0] op_prod_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [IW-1:0]   rd_idx_i,
    output logic [DW-1:0]   rd_hi_o,
    output logic [DW-1:0]   rd_lo_o,
    output logic            rd_ovf_o,
    output logic            pend_o,
    output logic [IW-1:0]   pend_idx_o
);

    logic [DW-1:0]   hi_q [NACC];
    logic [DW-1:0]   lo_q [NACC];
    logic [NACC-1:0] ovf_q;

    stage_ctrl_t     st_q,      st_d;
    logic [IW-1:0]   st_idx_q,  st_idx_d;
    logic [DW-1:0]   st_hi_q,   st_hi_d;
    logic [DW-1:0]   st_lo_q,   st_lo_d;
    logic [2*DW-1:0] st_prod_q, st_prod_d;

    logic          commit;
    logic [DW-1:0] res_hi;
    logic [DW-1:0] res_lo;
    logic          res_ovf;

    assign op_ready_o = ~stall_i;
    assign commit     = st_q.valid & ~stall_i & ~flush_i;
    assign pend_o     = st_q.valid;
    assign pend_idx_o = st_idx_q;

    // Fed from the staged target's live registers, so back-to-back ops chain correctly.
    hilo_acc_alu #(
        .DW (DW)
    ) u_alu (
        .op_i      (st_q.op),
        .sgn_i     (st_q.sgn),
        .we_i      (st_q.we),
        .acc_hi_i  (hi_q[st_idx_q]),
        .acc_lo_i  (lo_q[st_idx_q]),
        .acc_ovf_i (ovf_q[st_idx_q]),
        .wr_hi_i   (st_hi_q),
        .wr_lo_i   (st_lo_q),
        .prod_i    (st_prod_q),
        .res_hi_o  (res_hi),
        .res_lo_o  (res_lo),
        .res_ovf_o (res_ovf)
    );

    always_comb begin
        st_d      = st_q;
        st_idx_d  = st_idx_q;
        st_hi_d   = st_hi_q;
        st_lo_d   = st_lo_q;
        st_prod_d = st_prod_q;
        if (flush_i) begin
            st_d.valid = 1'b0;
        end else if (!stall_i) begin
            st_d      = '{valid: op_valid_i, op: op_i, sgn: op_signed_i, we: op_we_i};
            st_idx_d  = op_idx_i;
            st_hi_d   = op_hi_i;
            st_lo_d   = op_lo_i;
            st_prod_d = op_prod_i;
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q      <= '0;
            st_idx_q  <= '0;
            st_hi_q   <= '0;
            st_lo_q   <= '0;
            st_prod_q <= '0;
            ovf_q     <= '0;
            for (int unsigned i = 0; i < NACC; i++) begin
                hi_q[i] <= '0;
                lo_q[i] <= '0;
            end
        end else begin
            st_q      <= st_d;
            st_idx_q  <= st_idx_d;
            st_hi_q   <= st_hi_d;
            st_lo_q   <= st_lo_d;
            st_prod_q <= st_prod_d;
            if (commit) begin
                hi_q[st_idx_q]  <= res_hi;
                lo_q[st_idx_q]  <= res_lo;
                ovf_q[st_idx_q] <= res_ovf;
            end
        end
    end

`ifdef HILO_BYPASS_EN
    logic byp;
    assign byp      = st_q.valid & (st_idx_q == rd_idx_i) & ~flush_i;
    assign rd_hi_o  = byp ? res_hi  : hi_q[rd_idx_i];
    assign rd_lo_o  = byp ? res_lo  : lo_q[rd_idx_i];
    assign rd_ovf_o = byp ? res_ovf : ovf_q[rd_idx_i];
`else
    assign rd_hi_o  = hi_q[rd_idx_i];
    assign rd_lo_o  = lo_q[rd_idx_i];
    assign rd_ovf_o = ovf_q[rd_idx_i];
`endif

endmodule
